// File: rtl/sid_write_sched.sv
// sid_write_sched
//   Voice-slot sequencer and buffered register-write scheduler for the SID core.
//   A frame is N_VOICES voice slots followed by one commit slot, each SLOT_CYCLES
//   clocks long. Host writes land in a small FIFO and are drained into the SID
//   register file only during the commit slot, so voice computations never see
//   a register change part-way through.
//
//   Optional feature macro: SID_WR_COALESCE_EN
//     When defined, a write whose address matches the newest FIFO entry (and
//     that entry is not leaving the FIFO this cycle) overwrites that entry's
//     data instead of taking a new slot.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   frame advance / commit enable
//   wr_valid    in   host write request
//   wr_addr     in   [4:0] SID register address
//   wr_data     in   [7:0] register data
//   wr_ready    out  FIFO not full (from registered occupancy)
//   ovf         out  sticky overflow, set by a write offered while full
//   reg_we      out  register-file write strobe (commit slot, FIFO non-empty)
//   reg_addr    out  [4:0] FIFO head address
//   reg_data    out  [7:0] FIFO head data
//   voice_sel   out  [2:0] active voice index
//   voice_start out  pulse on the first cycle of each voice slot
//   sample_tick out  pulse on the last cycle of a frame
module sid_write_sched #(
  parameter int N_VOICES    = 3,
  parameter int SLOT_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_valid,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       ovf,
  output logic       reg_we,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_data,
  output logic [2:0] voice_sel,
  output logic       voice_start,
  output logic       sample_tick
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SW = $clog2(N_VOICES + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [SW-1:0] COMMIT_SLOT = SW'(N_VOICES);
  localparam logic [CW-1:0] LAST_CYC    = CW'(SLOT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT    = (AW+1)'(DEPTH);
  localparam logic [2:0]    LAST_VOICE  = 3'(N_VOICES - 1);

  logic [SW-1:0] r_slot;
  logic [CW-1:0] r_cyc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [4:0]    r_mem_addr [DEPTH];
  logic [7:0]    r_mem_data [DEPTH];

  logic w_commit_slot;
  logic w_cyc_last;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_coal;

  assign w_commit_slot = (r_slot == COMMIT_SLOT);
  assign w_cyc_last    = (r_cyc == LAST_CYC);

  // Frame counters: cycle within slot, slot within frame; frozen while ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_cyc  <= '0;
    end else if (ena) begin
      if (w_cyc_last) begin
        r_cyc  <= '0;
        r_slot <= w_commit_slot ? '0 : r_slot + SW'(1);
      end else begin
        r_cyc <= r_cyc + CW'(1);
      end
    end
  end

  // During the commit slot the voice index parks on the last voice.
  assign voice_sel   = w_commit_slot ? LAST_VOICE : 3'(r_slot);
  assign voice_start = ena & (r_cyc == '0) & ~w_commit_slot;
  assign sample_tick = ena & w_commit_slot & w_cyc_last;

  // Readiness comes from the registered count only, so a same-cycle pop
  // never makes room for a push into a full FIFO.
  assign wr_ready = (r_count != FULL_CNT);
  assign w_accept = wr_valid & wr_ready;
  assign reg_we   = ena & w_commit_slot & (r_count != '0);
  assign w_pop    = reg_we;
  assign reg_addr = r_mem_addr[r_rptr];
  assign reg_data = r_mem_data[r_rptr];

`ifdef SID_WR_COALESCE_EN
  logic [AW-1:0] w_tail_ptr;
  assign w_tail_ptr = r_wptr - AW'(1);
  // With a single entry being popped, the tail is leaving: push instead.
  assign w_coal = w_accept & (r_count != '0) &
                  (wr_addr == r_mem_addr[w_tail_ptr]) &
                  ~(w_pop & (r_count == (AW+1)'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign w_push = w_accept & ~w_coal;

  // FIFO control state and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (wr_valid & ~wr_ready) r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

  // FIFO storage; contents are only meaningful under the control pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= wr_addr;
      r_mem_data[r_wptr] <= wr_data;
    end
`ifdef SID_WR_COALESCE_EN
    if (w_coal) r_mem_data[w_tail_ptr] <= wr_data;
`endif
  end

endmodule
